// File: rtl/pdp11_io_ctrl_pkg.sv
// Shared register map, timer register offsets, edge-select codes and CTRL bit positions
// for the PDP-11 GPIO/timer/interrupt peripheral.
package pdp11_io_ctrl_pkg;

  localparam logic [7:0] A_DDR      = 8'd0;
  localparam logic [7:0] A_PORT     = 8'd1;
  localparam logic [7:0] A_PIN      = 8'd2;
  localparam logic [7:0] A_INT_EN   = 8'd3;
  localparam logic [7:0] A_EDGE     = 8'd4;
  localparam logic [7:0] A_PEND     = 8'd5;
  localparam logic [7:0] A_TMR_BASE = 8'd8;
  localparam int unsigned TMR_STRIDE = 4;

  typedef enum logic [1:0] {
    T_PRE  = 2'd0,
    T_TOP  = 2'd1,
    T_CNT  = 2'd2,
    T_CTRL = 2'd3
  } tmr_reg_e;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10
  } edge_e;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  // Codes 2'b10 and 2'b11 both select either-edge detection.
  function automatic logic edge_hit(input logic [1:0] code, input logic cur, input logic prev);
    if (code[1])      return cur ^ prev;
    else if (code[0]) return prev & ~cur;
    else              return cur & ~prev;
  endfunction

endpackage

// File: rtl/pdp11_io_ctrl_if.sv
// Core-side I/O port of the peripheral: register access bus plus interrupt request/acknowledge.
interface pdp11_io_ctrl_if #(parameter int unsigned IRQ_W = 7);
  logic [7:0]       io_addr;
  logic [15:0]      io_wdata;
  logic             io_wen;
  logic [15:0]      io_rdata;
  logic [IRQ_W-1:0] irq;
  logic [IRQ_W-1:0] irq_ack;

  modport master (output io_addr, io_wdata, io_wen, irq_ack, input io_rdata, irq);
  modport slave  (input io_addr, io_wdata, io_wen, irq_ack, output io_rdata, irq);
endinterface

// File: rtl/pdp11_io_ctrl_timer.sv
// One timer channel: PRE/TOP/CNT/CTRL registers, prescaler and an expiry pulse gated by irq_en.
module pdp11_io_timer
  import pdp11_io_ctrl_pkg::*;
#(
  parameter logic [15:0] PRE_RST = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  tmr_reg_e    reg_sel,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq_set
);

  logic [15:0] pre, top, cnt, pre_ctr;
  logic [2:0]  ctrl;
  logic [15:0] pre_n, top_n, cnt_n, pre_ctr_n;
  logic [2:0]  ctrl_n;
  logic [16:0] pc_inc, pre_lim;
  logic        tick, expire;

  always_comb begin
    pc_inc  = {1'b0, pre_ctr} + 17'd1;
    pre_lim = (pre == '0) ? 17'd1 : {1'b0, pre};
    tick    = ctrl[CTRL_RUN] && (pc_inc >= pre_lim);
    expire  = tick && (cnt >= top);
    irq_set = expire && ctrl[CTRL_IRQ_EN];
  end

  // Tick effects first, then any CPU write overrides the register it targets.
  always_comb begin
    pre_n     = pre;
    top_n     = top;
    cnt_n     = cnt;
    ctrl_n    = ctrl;
    pre_ctr_n = pre_ctr;
    if (ctrl[CTRL_RUN]) pre_ctr_n = tick ? '0 : pc_inc[15:0];
    if (tick) begin
      if (expire) begin
        cnt_n            = '0;
        ctrl_n[CTRL_RUN] = ~ctrl[CTRL_ONESHOT];
      end else begin
        cnt_n = cnt + 16'd1;
      end
    end
    if (wr_en) begin
      case (reg_sel)
        T_PRE:   begin pre_n = wdata; pre_ctr_n = '0; end
        T_TOP:   top_n = wdata;
        T_CNT:   begin cnt_n = wdata; pre_ctr_n = '0; end
        default: ctrl_n = wdata[2:0];
      endcase
    end
  end

  // Timers free-run after reset with their interrupts disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= PRE_RST;
      top     <= 16'h8000;
      cnt     <= '0;
      pre_ctr <= '0;
      ctrl    <= 3'b001;
    end else begin
      pre     <= pre_n;
      top     <= top_n;
      cnt     <= cnt_n;
      pre_ctr <= pre_ctr_n;
      ctrl    <= ctrl_n;
    end
  end

  always_comb begin
    case (reg_sel)
      T_PRE:   rdata = pre;
      T_TOP:   rdata = top;
      T_CNT:   rdata = cnt;
      default: rdata = {13'd0, ctrl};
    endcase
  end

endmodule

// File: rtl/pdp11_io_ctrl.sv
// PDP-11 I/O peripheral: GPIO with DDR/PORT, synchronised pin-change interrupts,
// N timer channels and a W1C pending register with a registered read port.
module pdp11_io_ctrl
  import pdp11_io_ctrl_pkg::*;
#(
  parameter int unsigned GPIO_W = 7,
  parameter int unsigned N_PINT = 5,
  parameter int unsigned N_TMR  = 2
) (
  input  logic              clk,
  input  logic              rst,
  pdp11_io_ctrl_if.slave    io,
  input  logic [GPIO_W-1:0] pin_in,
  output logic [GPIO_W-1:0] pin_out,
  output logic [GPIO_W-1:0] pin_oeb
);

  localparam int unsigned IRQ_W   = N_TMR + N_PINT;
  localparam logic [15:0] IEN_MSK = 16'((32'd1 << N_PINT) - 32'd1);
  localparam logic [15:0] EDG_MSK = 16'((32'd1 << (2 * N_PINT)) - 32'd1);

  logic [GPIO_W-1:0] ddr, port, s1, s2, sp;
  logic [15:0]       int_en, edge_sel, rdata_q, rd_val;
  logic [IRQ_W-1:0]  pend, pend_set, w1c;
  logic [15:0]       tmr_rdata [N_TMR];
  logic [N_TMR-1:0]  tmr_set;
  tmr_reg_e          reg_sel;

  assign reg_sel     = tmr_reg_e'(io.io_addr[1:0]);
  assign pin_out     = port;
  assign pin_oeb     = ~ddr;
  assign io.irq      = pend;
  assign io.io_rdata = rdata_q;

  for (genvar t = 0; t < N_TMR; t++) begin : g_tmr
    logic wr;
    assign wr = io.io_wen && (io.io_addr[7:2] == 6'(t + 2));
    pdp11_io_timer #(.PRE_RST(16'(16 << t))) u_tmr (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr),
      .reg_sel (reg_sel),
      .wdata   (io.io_wdata),
      .rdata   (tmr_rdata[t]),
      .irq_set (tmr_set[t])
    );
  end

  always_comb begin
    pend_set            = '0;
    pend_set[N_TMR-1:0] = tmr_set;
    for (int unsigned i = 0; i < N_PINT; i++)
      pend_set[N_TMR+i] = int_en[i] && edge_hit(edge_sel[2*i +: 2], s2[i], sp[i]);
    w1c = (io.io_wen && io.io_addr == A_PEND) ? io.io_wdata[IRQ_W-1:0] : '0;
  end

  always_comb begin
    rd_val = 16'hFFFF;
    case (io.io_addr)
      A_DDR:    rd_val = 16'(ddr);
      A_PORT:   rd_val = 16'(port);
      A_PIN:    rd_val = 16'(s2);
      A_INT_EN: rd_val = int_en;
      A_EDGE:   rd_val = edge_sel;
      A_PEND:   rd_val = 16'(pend);
      default: begin
        for (int unsigned t = 0; t < N_TMR; t++)
          if (io.io_addr[7:2] == 6'(t + 2)) rd_val = tmr_rdata[t];
      end
    endcase
  end

  // Set beats clear so an event coinciding with ack/W1C is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr      <= '0;
      port     <= '0;
      s1       <= '0;
      s2       <= '0;
      sp       <= '0;
      int_en   <= '0;
      edge_sel <= '0;
      pend     <= '0;
      rdata_q  <= '0;
    end else begin
      s1   <= pin_in;
      s2   <= s1;
      sp   <= s2;
      pend <= pend_set | (pend & ~(io.irq_ack | w1c));
      if (!io.io_wen) begin
        rdata_q <= rd_val;
      end else begin
        case (io.io_addr)
          A_DDR:    ddr      <= io.io_wdata[GPIO_W-1:0];
          A_PORT:   port     <= io.io_wdata[GPIO_W-1:0];
          A_INT_EN: int_en   <= io.io_wdata & IEN_MSK;
          A_EDGE:   edge_sel <= io.io_wdata & EDG_MSK;
          default:  ;
        endcase
      end
    end
  end

endmodule
